// File: rtl/npc_exec_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer for the NPC core.
// Optional bus-handshake timeout is enabled by defining NPC_SEQ_TIMEOUT_EN.
module npc_exec_sequencer #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  input  logic             ifu_rsp_valid,
  output logic             ir_we,
  input  logic             dec_ld,
  input  logic             dec_st,
  input  logic             dec_rd_en,
  input  logic             dec_halt,
  output logic             lsu_req_valid,
  output logic             lsu_req_we,
  input  logic             lsu_req_ready,
  input  logic             lsu_rsp_valid,
  output logic             rf_we,
  output logic             pc_we,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_IWAIT, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  state_t state, state_nxt;
  logic   timeout;
  logic   waiting;

  assign waiting = (state == S_FETCH) || (state == S_IWAIT) ||
                   (state == S_MEM)   || (state == S_MWAIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; handshake progress wins over a coincident timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (ifu_req_ready)      state_nxt = S_IWAIT;
               else if (timeout)       state_nxt = S_HALT;
      S_IWAIT: if (ifu_rsp_valid)      state_nxt = S_EXEC;
               else if (timeout)       state_nxt = S_HALT;
      S_EXEC:  if (dec_halt)           state_nxt = S_HALT;
               else if (dec_ld || dec_st) state_nxt = S_MEM;
               else                    state_nxt = S_WB;
      S_MEM:   if (lsu_req_ready)      state_nxt = S_MWAIT;
               else if (timeout)       state_nxt = S_HALT;
      S_MWAIT: if (lsu_rsp_valid)      state_nxt = S_WB;
               else if (timeout)       state_nxt = S_HALT;
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the registered state
  always_comb begin
    ifu_req_valid = 1'b0;
    ir_we         = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_we    = 1'b0;
    rf_we         = 1'b0;
    pc_we         = 1'b0;
    halted        = 1'b0;
    unique case (state)
      S_FETCH: ifu_req_valid = 1'b1;
      S_IWAIT: ir_we         = ifu_rsp_valid;
      S_MEM: begin
        lsu_req_valid = 1'b1;
        lsu_req_we    = dec_st;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = dec_rd_en & ~dec_st;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              instret <= '0;
    else if (state == S_WB)  instret <= instret + CNT_W'(1);
  end

`ifdef NPC_SEQ_TIMEOUT_EN
  localparam int unsigned WAIT_W =
    ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [WAIT_W-1:0] wait_cnt;

  // Counter holds the cycles already spent in the current wait state
  assign timeout = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (waiting)            wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                bus_err <= 1'b0;
    else if (timeout && state_nxt == S_HALT)   bus_err <= 1'b1;
  end
`else
  // TIMEOUT_CYC only matters in the timeout build; referenced here to keep it live
  assign timeout = waiting & (TIMEOUT_CYC == 0) & 1'b0;
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_npc_exec_sequencer.sv
// Scoreboard bench for npc_exec_sequencer: directed instruction sequences,
// expected retirements and LSU requests queued by the driver, checked by a monitor.
module tb_npc_exec_sequencer;
  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ir_we;
  logic             dec_ld, dec_st, dec_rd_en, dec_halt;
  logic             lsu_req_valid, lsu_req_we, lsu_req_ready, lsu_rsp_valid;
  logic             rf_we, pc_we, halted, bus_err;
  logic [CNT_W-1:0] instret;

  npc_exec_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ir_we(ir_we),
    .dec_ld(dec_ld), .dec_st(dec_st), .dec_rd_en(dec_rd_en), .dec_halt(dec_halt),
    .lsu_req_valid(lsu_req_valid), .lsu_req_we(lsu_req_we),
    .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
    .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .bus_err(bus_err),
    .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic rf_we; logic [31:0] instret; } ret_t;
  typedef struct { logic we; int hold; } lsu_t;
  ret_t ret_q[$];
  lsu_t lsu_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input string name);
    int i = 0;
    while (!ifu_req_valid && i < 50) begin tick(1); i++; end
    check(name, 32'(ifu_req_valid), 32'd1);
  endtask

  task automatic wait_lsu(input string name);
    int i = 0;
    while (!lsu_req_valid && i < 50) begin tick(1); i++; end
    check(name, 32'(lsu_req_valid), 32'd1);
  endtask

  task automatic wait_pc(input string name);
    int i = 0;
    while (!pc_we && i < 50) begin tick(1); i++; end
    check(name, 32'(pc_we), 32'd1);
  endtask

  // Monitor: pops expectations on LSU acceptance and on each retirement
  int   ir_cnt   = 0;
  int   hold_cnt = 0;
  ret_t re;
  lsu_t le;
  always @(negedge clk) begin
    if (!rst_n) begin
      ir_cnt   = 0;
      hold_cnt = 0;
    end else begin
      if (ir_we) ir_cnt++;
      if (lsu_req_valid) begin
        hold_cnt++;
        if (lsu_req_ready) begin
          if (lsu_q.size() == 0) check("lsu_unexpected", 32'd1, 32'd0);
          else begin
            le = lsu_q.pop_front();
            check("lsu_req_we", 32'(lsu_req_we), 32'(le.we));
            check("lsu_hold", 32'(hold_cnt), 32'(le.hold));
          end
          hold_cnt = 0;
        end
      end
      if (pc_we) begin
        if (ret_q.size() == 0) check("retire_unexpected", 32'd1, 32'd0);
        else begin
          re = ret_q.pop_front();
          check("rf_we", 32'(rf_we), 32'(re.rf_we));
          check("instret_wb", instret, re.instret);
          check("ir_we_pulses", 32'(ir_cnt), 32'd1);
        end
        ir_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int act;
    rst_n = 1'b0;
    ifu_req_ready = 0; ifu_rsp_valid = 0;
    dec_ld = 0; dec_st = 0; dec_rd_en = 0; dec_halt = 0;
    lsu_req_ready = 0; lsu_rsp_valid = 0;
    tick(3);
    check("rst_ifu_req_valid", 32'(ifu_req_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_instret", instret, 32'd0);

    // ALU instructions on zero-wait buses: 4 cycles each
    ifu_req_ready = 1; ifu_rsp_valid = 1; dec_rd_en = 1;
    for (int i = 0; i < 5; i++) ret_q.push_back('{1'b1, 32'(i)});
    rst_n = 1'b1;
    check("idle_no_fetch", 32'(ifu_req_valid), 32'd0);
    tick(1);
    check("first_fetch", 32'(ifu_req_valid), 32'd1);
    tick(19);
    check("instret_after_20", instret, 32'd4);
    tick(1);

    // Load: LSU ready after 3 wait cycles, response after 2
    wait_fetch("wait_fetch_ld");
    dec_ld = 1; lsu_req_ready = 0; lsu_rsp_valid = 0;
    lsu_q.push_back('{1'b0, 4});
    ret_q.push_back('{1'b1, 32'd5});
    wait_lsu("wait_mem_ld");
    tick(3);
    lsu_req_ready = 1;
    tick(1);
    lsu_req_ready = 0;
    check("mwait_no_req", 32'(lsu_req_valid), 32'd0);
    tick(2);
    lsu_rsp_valid = 1;
    tick(1);
    lsu_rsp_valid = 0;
    check("ld_wb_rf_we", 32'(rf_we), 32'd1);

    // Store: no register write, still retires
    wait_fetch("wait_fetch_st");
    dec_ld = 0; dec_st = 1; lsu_req_ready = 1; lsu_rsp_valid = 1;
    lsu_q.push_back('{1'b1, 1});
    ret_q.push_back('{1'b0, 32'd6});
    wait_pc("wait_wb_st");
    wait_fetch("wait_fetch_halt");
    check("instret_after_st", instret, 32'd7);

    // ebreak together with a load: halt wins, no memory request
    dec_st = 0; dec_ld = 1; dec_halt = 1;
    act = 0;
    while (!halted && act < 20) begin tick(1); act++; end
    check("halt_reached", 32'(halted), 32'd1);
    act = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (ifu_req_valid || lsu_req_valid || ir_we || pc_we || rf_we || !halted ||
          instret != 32'd7 || bus_err) act++;
    end
    check("halt_frozen", 32'(act), 32'd0);
    check("halt_instret", instret, 32'd7);

    // Reset releases halt
    rst_n = 1'b0;
    #1;
    check("rst_from_halt", 32'(halted), 32'd0);
    check("rst_from_halt_instret", instret, 32'd0);
    dec_halt = 0; dec_ld = 0;
    ret_q.push_back('{1'b1, 32'd0});
    tick(1);
    rst_n = 1'b1;
    wait_pc("wait_wb_alu2");
    wait_fetch("wait_fetch_ld2");

    // Load aborted by reset while waiting for the LSU response
    dec_ld = 1; lsu_req_ready = 1; lsu_rsp_valid = 0;
    lsu_q.push_back('{1'b0, 1});
    wait_lsu("wait_mem_ld2");
    tick(1);
    check("mwait_instret", instret, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_lsu_req_valid", 32'(lsu_req_valid), 32'd0);
    check("abort_halted", 32'(halted), 32'd0);
    check("abort_instret", instret, 32'd0);
    dec_ld = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_idle", 32'(ifu_req_valid), 32'd0);
    tick(1);
    check("abort_refetch", 32'(ifu_req_valid), 32'd1);

    // Fetch never accepted
    rst_n = 1'b0;
    ifu_req_ready = 0;
    tick(1);
    rst_n = 1'b1;
`ifdef NPC_SEQ_TIMEOUT_EN
    tick(16);
    check("to_pre_halted", 32'(halted), 32'd0);
    check("to_pre_bus_err", 32'(bus_err), 32'd0);
    check("to_pre_fetch", 32'(ifu_req_valid), 32'd1);
    tick(1);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_halted", 32'(halted), 32'd1);
    check("to_no_fetch", 32'(ifu_req_valid), 32'd0);
    tick(5);
    check("to_bus_err_sticky", 32'(bus_err), 32'd1);
`else
    tick(1);
    act = 0;
    for (int i = 0; i < 300; i++) begin
      if (!ifu_req_valid || bus_err || halted) act++;
      tick(1);
    end
    check("no_timeout_fetch_held", 32'(act), 32'd0);
    check("no_timeout_bus_err", 32'(bus_err), 32'd0);
`endif

    check("ret_q_drained", 32'(ret_q.size()), 32'd0);
    check("lsu_q_drained", 32'(lsu_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
